// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: steps one shared full-adder cell over WIDTH cycles,
// LSB first, producing {cout, sum} = a + b + cin and a signed-overflow flag.

module serial_add_fa (
    input  logic x_i,
    input  logic y_i,
    input  logic z_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = x_i ^ y_i ^ z_i;
    assign c_o = (x_i & y_i) | (y_i & z_i) | (z_i & x_i);
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               fa_s, fa_c;

    serial_add_fa u_fa (
        .x_i (a_q[0]),
        .y_i (b_q[0]),
        .z_i (carry_q),
        .s_o (fa_s),
        .c_o (fa_c)
    );

    // NOTE: every _d gets its hold value first so no path through the case leaves
    // a signal unassigned; that is what keeps this block free of inferred latches.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            RUN: begin
                // Result bits enter at the MSB so bit i lands in sum[i] after WIDTH shifts.
                sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = fa_c;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    cout_d  = fa_c;
                    ovf_d   = carry_q ^ fa_c;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values, independent of the order the statements are written in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and randomised checks of serial_add_ctrl at WIDTH=8 and WIDTH=3.

module tb_serial_add_ctrl;

    logic       clk;
    logic       rst;

    logic       s8_start, s8_cin, s8_busy, s8_done, s8_cout, s8_ovf;
    logic [7:0] s8_a, s8_b, s8_sum;

    logic       s3_start, s3_cin, s3_busy, s3_done, s3_cout, s3_ovf;
    logic [2:0] s3_a, s3_b, s3_sum;

    int vectors;
    int miscompares;
    int done8_cnt;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (s8_start),
        .a     (s8_a),
        .b     (s8_b),
        .cin   (s8_cin),
        .busy  (s8_busy),
        .done  (s8_done),
        .sum   (s8_sum),
        .cout  (s8_cout),
        .ovf   (s8_ovf)
    );

    serial_add_ctrl #(.WIDTH(3)) dut3 (
        .clk   (clk),
        .rst   (rst),
        .start (s3_start),
        .a     (s3_a),
        .b     (s3_b),
        .cin   (s3_cin),
        .busy  (s3_busy),
        .done  (s3_done),
        .sum   (s3_sum),
        .cout  (s3_cout),
        .ovf   (s3_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (s8_done === 1'b1) done8_cnt++;
    end

    // Starts one WIDTH=8 add from IDLE and returns in the done cycle (negedge).
    // Operands are scrambled right after acceptance; they must not matter.
    task automatic run_op8(input logic [7:0] op_a, input logic [7:0] op_b, input logic op_cin,
                           output int busy_cycles, output int lat, output logic timed_out);
        @(negedge clk);
        s8_start = 1'b1;
        s8_a     = op_a;
        s8_b     = op_b;
        s8_cin   = op_cin;
        @(negedge clk);
        s8_start = 1'b0;
        s8_a     = ~op_a;
        s8_b     = ~op_b;
        s8_cin   = ~op_cin;
        busy_cycles = 0;
        lat         = 0;
        while (s8_done !== 1'b1 && lat < 30) begin
            if (s8_busy === 1'b1) busy_cycles++;
            @(negedge clk);
            lat++;
        end
        timed_out = (s8_done !== 1'b1);
    endtask

    task automatic drive(input int w, input logic st, input logic [7:0] da, input logic [7:0] db,
                         input logic dc);
        if (w == 8) begin
            s8_start = st; s8_a = da; s8_b = db; s8_cin = dc;
        end else begin
            s3_start = st; s3_a = da[2:0]; s3_b = db[2:0]; s3_cin = dc;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({s8_busy, s8_done, s8_cout, s8_ovf, s8_sum} !== 12'h000) begin
            miscompares++;
            $display("FAIL reset_w8: busy/done/cout/ovf/sum=%b/%b/%b/%b/%h want 0/0/0/0/00",
                     s8_busy, s8_done, s8_cout, s8_ovf, s8_sum);
        end
        vectors++;
        if ({s3_busy, s3_done, s3_cout, s3_ovf, s3_sum} !== 7'h00) begin
            miscompares++;
            $display("FAIL reset_w3: busy/done/cout/ovf/sum=%b/%b/%b/%b/%h want 0/0/0/0/0",
                     s3_busy, s3_done, s3_cout, s3_ovf, s3_sum);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int bc, lat, d0;
        logic to;
        d0 = done8_cnt;
        run_op8(8'h0F, 8'h01, 1'b0, bc, lat, to);
        vectors++;
        if (to) begin
            miscompares++;
            $display("FAIL basic_timeout: no done within 30 cycles");
            return;
        end
        vectors++;
        if (bc != 8) begin
            miscompares++;
            $display("FAIL basic_busy_cycles: got %0d want 8", bc);
        end
        vectors++;
        if (lat != 8) begin
            miscompares++;
            $display("FAIL basic_latency: got %0d want 8", lat);
        end
        vectors++;
        if ({s8_busy, s8_cout, s8_ovf, s8_sum} !== {1'b0, 1'b0, 1'b0, 8'h10}) begin
            miscompares++;
            $display("FAIL basic_result: busy/cout/ovf/sum=%b/%b/%b/%h want 0/0/0/10",
                     s8_busy, s8_cout, s8_ovf, s8_sum);
        end
        @(negedge clk);
        vectors++;
        if ({s8_done, s8_busy, s8_sum} !== {1'b0, 1'b0, 8'h10}) begin
            miscompares++;
            $display("FAIL basic_done_pulse: done/busy/sum=%b/%b/%h want 0/0/10",
                     s8_done, s8_busy, s8_sum);
        end
        vectors++;
        if (done8_cnt != d0 + 1) begin
            miscompares++;
            $display("FAIL basic_done_count: got %0d want %0d", done8_cnt - d0, 1);
        end
    endtask

    task automatic test_carry_ovf();
        logic [7:0] ta [4]  = '{8'hFF, 8'h7F, 8'hFF, 8'h80};
        logic [7:0] tb_ [4] = '{8'h01, 8'h01, 8'hFF, 8'h80};
        logic       tc [4]  = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [9:0] te [4]  = '{{1'b1, 1'b0, 8'h00}, {1'b0, 1'b1, 8'h80},
                                {1'b1, 1'b0, 8'hFF}, {1'b1, 1'b1, 8'h00}};
        int bc, lat;
        logic to;
        for (int i = 0; i < 4; i++) begin
            run_op8(ta[i], tb_[i], tc[i], bc, lat, to);
            vectors++;
            if (to || {s8_cout, s8_ovf, s8_sum} !== te[i]) begin
                miscompares++;
                $display("FAIL carry_ovf_%0d: timeout=%b cout/ovf/sum=%b/%b/%h want %b/%b/%h",
                         i, to, s8_cout, s8_ovf, s8_sum, te[i][9], te[i][8], te[i][7:0]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        int n, d0;
        d0 = done8_cnt;
        @(negedge clk);
        s8_start = 1'b1; s8_a = 8'h0F; s8_b = 8'h01; s8_cin = 1'b0;
        @(negedge clk);
        s8_a = 8'h55; s8_b = 8'h22;
        n = 0;
        while (s8_done !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (s8_done !== 1'b1 || s8_sum !== 8'h10) begin
            miscompares++;
            $display("FAIL b2b_first: done=%b sum=%h want 1/10", s8_done, s8_sum);
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                vectors++;
                if (done8_cnt != d0 + 1 || s8_done !== 1'b0) begin
                    miscompares++;
                    $display("FAIL b2b_single_pulse: pulses=%0d done=%b want 1/0",
                             done8_cnt - d0, s8_done);
                end
            end
        end while (s8_done !== 1'b1 && n < 30);
        vectors++;
        if (n != 10) begin
            miscompares++;
            $display("FAIL b2b_restart_gap: got %0d cycles want 10", n);
        end
        vectors++;
        if ({s8_cout, s8_ovf, s8_sum} !== {1'b0, 1'b0, 8'h77}) begin
            miscompares++;
            $display("FAIL b2b_second: cout/ovf/sum=%b/%b/%h want 0/0/77", s8_cout, s8_ovf, s8_sum);
        end
        s8_start = 1'b0;
        @(negedge clk);
        vectors++;
        if (done8_cnt != d0 + 2) begin
            miscompares++;
            $display("FAIL b2b_pulse_count: got %0d want 2", done8_cnt - d0);
        end
    endtask

    task automatic test_async_reset();
        int bc, lat, d0;
        logic to;
        @(negedge clk);
        s8_start = 1'b1; s8_a = 8'hFF; s8_b = 8'h00; s8_cin = 1'b0;
        @(negedge clk);
        s8_start = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (s8_busy !== 1'b1 || s8_sum === 8'h00) begin
            miscompares++;
            $display("FAIL areset_pre: busy=%b sum=%h want busy 1, sum nonzero", s8_busy, s8_sum);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({s8_busy, s8_done, s8_cout, s8_ovf, s8_sum} !== 12'h000) begin
            miscompares++;
            $display("FAIL areset_immediate: busy/done/cout/ovf/sum=%b/%b/%b/%b/%h want all 0",
                     s8_busy, s8_done, s8_cout, s8_ovf, s8_sum);
        end
        @(negedge clk);
        rst = 1'b0;
        d0 = done8_cnt;
        repeat (15) @(negedge clk);
        vectors++;
        if (done8_cnt != d0 || s8_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL areset_quiet: pulses=%0d busy=%b want 0/0", done8_cnt - d0, s8_busy);
        end
        run_op8(8'h01, 8'h02, 1'b0, bc, lat, to);
        vectors++;
        if (to || {s8_cout, s8_ovf, s8_sum} !== {1'b0, 1'b0, 8'h03}) begin
            miscompares++;
            $display("FAIL areset_fresh: timeout=%b cout/ovf/sum=%b/%b/%h want 0/0/03",
                     to, s8_cout, s8_ovf, s8_sum);
        end
        @(negedge clk);
    endtask

    // Continuous start: each result is checked in its done cycle and the next
    // operands are presented then, to be captured on the following IDLE edge.
    task automatic test_random(input int w, input int n);
        logic [7:0] mask, ea, eb, exp_sum, got_sum;
        logic       ec, exp_cout, exp_ovf, got_cout, got_ovf, got_done;
        logic [8:0] full;
        int gap;
        mask = (w == 8) ? 8'hFF : 8'h07;
        @(negedge clk);
        ea = 8'($urandom) & mask; eb = 8'($urandom) & mask; ec = 1'($urandom);
        drive(w, 1'b1, ea, eb, ec);
        for (int k = 0; k < n; k++) begin
            gap = 0;
            do begin
                @(negedge clk);
                gap++;
                got_done = (w == 8) ? s8_done : s3_done;
            end while (got_done !== 1'b1 && gap < 40);
            full     = {1'b0, ea} + {1'b0, eb} + {8'h00, ec};
            exp_sum  = full[7:0] & mask;
            exp_cout = full[w];
            exp_ovf  = (ea[w-1] == eb[w-1]) && (exp_sum[w-1] != ea[w-1]);
            got_sum  = (w == 8) ? s8_sum : {5'b0, s3_sum};
            got_cout = (w == 8) ? s8_cout : s3_cout;
            got_ovf  = (w == 8) ? s8_ovf : s3_ovf;
            vectors++;
            if (got_done !== 1'b1 || {got_cout, got_ovf, got_sum} !== {exp_cout, exp_ovf, exp_sum}) begin
                miscompares++;
                $display("FAIL rand_w%0d_%0d: %h+%h+%b done=%b cout/ovf/sum=%b/%b/%h want %b/%b/%h",
                         w, k, ea, eb, ec, got_done, got_cout, got_ovf, got_sum,
                         exp_cout, exp_ovf, exp_sum);
                if (got_done !== 1'b1) break;
            end
            if (k > 0) begin
                vectors++;
                if (gap != w + 2) begin
                    miscompares++;
                    $display("FAIL rand_w%0d_period_%0d: got %0d cycles want %0d", w, k, gap, w + 2);
                end
            end
            ea = 8'($urandom) & mask; eb = 8'($urandom) & mask; ec = 1'($urandom);
            drive(w, 1'b1, ea, eb, ec);
        end
        drive(w, 1'b0, 8'h00, 8'h00, 1'b0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        done8_cnt   = 0;
        drive(8, 1'b0, 8'h00, 8'h00, 1'b0);
        drive(3, 1'b0, 8'h00, 8'h00, 1'b0);
        test_reset();
        test_basic();
        test_carry_ovf();
        test_back_to_back();
        test_async_reset();
        test_random(8, 1000);
        test_random(3, 1000);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial adder controller. It sequences a single one-bit full-adder cell over WIDTH clock cycles, LSB first, to add two WIDTH-bit operands plus a carry-in. It sits between a requesting datapath and the shared full-adder resource, trading area for latency. It owns the operand shift registers, the carry flip-flop, the bit counter and the start/busy/done handshake.

Parameters:
WIDTH, 8, operand/result width in bits; legal range WIDTH >= 2.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-high
start  input  1  request; sampled only in IDLE
a  input  WIDTH  operand A; captured on accepted start
b  input  WIDTH  operand B; captured on accepted start
cin  input  1  carry-in; captured on accepted start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse; result valid
sum  output  WIDTH  result; held until next accepted start
cout  output  1  carry out of the MSB
ovf  output  1  signed overflow (carry into MSB XOR carry out of MSB)

Behaviour:
- Reset is asynchronous and active-high. While rst=1: state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, counter=0, carry FF=0, and both operand shift registers=0. Reset asserted mid-RUN aborts the operation. No partial result is retained.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on a clock edge with start=1. That edge loads a and b into the shift registers, loads cin into the carry FF, clears the counter, and clears sum, cout and ovf.
  - RUN: each edge performs one full-adder step on bit0 of A, bit0 of B and the carry FF.
    - The sum bit shifts into sum at the MSB end (right shift). After WIDTH steps, bit i of the result sits at sum[i].
    - The carry FF takes the step's carry.
    - The operand registers shift right.
    - The counter increments.
  - RUN -> DONE on the edge that performs step WIDTH-1 (counter == WIDTH-1). On that edge:
    - cout <= final carry.
    - ovf <= carry-in of step WIDTH-1 XOR carry-out of step WIDTH-1.
  - DONE -> IDLE unconditionally on the next edge.
- Timing, with start accepted at edge E0:
  - busy=1 from E0 through edge E0+WIDTH.
  - done=1 for exactly the cycle between edges E0+WIDTH and E0+WIDTH+1.
  - Result latency is WIDTH cycles. Throughput is one add per WIDTH+2 cycles (IDLE, WIDTH RUN cycles, DONE).
- done and busy are registered, state-decoded outputs, never both high. They are mutually exclusive with IDLE.
- sum, cout and ovf are stable from the done cycle until the next accepted start. During RUN, sum holds partial shift contents and is not valid.
- start in RUN or DONE is ignored. It is not queued, and a/b/cin changes in those states have no effect.
- Arithmetic: {cout, sum} = a + b + cin, modulo 2^(WIDTH+1). No sign extension is applied. ovf is meaningful for two's-complement operands only.
- Full-adder step: s = x^y^z, c = xy | yz | zx. It is implemented as one instance of the existing one-bit full-adder cell. No wider adder is permitted.
- Counter width is $clog2(WIDTH). It wraps only through the RUN -> DONE transition and never overflows.

Test Plan:
1. WIDTH=8, start with a=8'h0F, b=8'h01, cin=0 -> busy high 8 cycles; done pulses once at E0+8; sum=8'h10, cout=0, ovf=0.
2. a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1, ovf=0. Then a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, cout=0, ovf=1.
3. a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1, ovf=0. a=8'h80, b=8'h80, cin=0 -> sum=8'h00, cout=1, ovf=1.
4. Start accepted, then start=1 with a=8'h55 held through RUN and DONE -> first result unaffected, exactly one done pulse. New operation begins only at the first IDLE edge with start=1 (done repeats at E_idle+8).
5. Assert rst asynchronously at RUN step 4, mid-cycle -> busy, done, sum, cout and ovf go 0 immediately without a clock edge. After release, no done pulse until a new start. A fresh a=8'h01, b=8'h02 -> sum=8'h03.
6. Random regression of 1000 adds with WIDTH=8 and WIDTH=3 -> {cout, sum} matches a+b+cin, ovf matches the signed check, and the done period is exactly WIDTH+2 cycles under a continuous start.
